// File: rtl/fifo_to_utx_ctrl.sv
// ============================================================================
// Module   : fifo_to_utx_ctrl
// Brief    : Transmit-side sequencer. Pops one DATA_FIFO-bit word from the
//            output FIFO and hands it to the UART transmitter one DATA-bit
//            byte at a time, LSB byte first, using a start/busy handshake.
//            A byte that is not acknowledged (tx_busy rise) within ACK_TO
//            cycles is re-sent up to MAX_RETRY times; after that the word is
//            dropped and the sticky err flag is raised.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_to_utx_ctrl #(
   parameter int DATA_FIFO = 64,
   parameter int DATA      = 8,
   parameter int N_BYTES   = DATA_FIFO / DATA,
   parameter int ACK_TO    = 16,
   parameter int MAX_RETRY = 3
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_l,
   input  logic                 en,
   input  logic                 clr_err,
   input  logic                 fifo_empty,
   input  logic [DATA_FIFO-1:0] fifo_dout,
   output logic                 pop,
   input  logic                 tx_busy,
   output logic                 tx_start,
   output logic [DATA-1:0]      tx_data,
   output logic                 busy,
   output logic                 err,
   output logic [15:0]          words_sent
);

   // Counter widths, guarded so degenerate parameter values still give
   // at least one bit.
   localparam int c_bc_w = (N_BYTES > 1)   ? $clog2(N_BYTES)       : 1;
   localparam int c_to_w = (ACK_TO > 1)    ? $clog2(ACK_TO)        : 1;
   localparam int c_rt_w = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [c_bc_w-1:0] c_last_byte = c_bc_w'(N_BYTES - 1);
   localparam logic [c_to_w-1:0] c_to_last   = c_to_w'(ACK_TO - 1);
   localparam logic [c_rt_w-1:0] c_max_retry = c_rt_w'(MAX_RETRY);
   localparam logic [c_bc_w-1:0] c_bc_one    = c_bc_w'(1);
   localparam logic [c_to_w-1:0] c_to_one    = c_to_w'(1);
   localparam logic [c_rt_w-1:0] c_rt_one    = c_rt_w'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_POP   = 3'd1,
      S_CAPT  = 3'd2,
      S_START = 3'd3,
      S_ACK   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                r_state;
   logic [DATA_FIFO-1:0]  r_shreg;
   logic [c_bc_w-1:0]     r_byte_cnt;
   logic [c_to_w-1:0]     r_to_cnt;
   logic [c_rt_w-1:0]     r_retry_cnt;
   logic [DATA_FIFO-1:0]  w_shreg_shift;

   // Word register advanced by one byte; its low byte is the next to send.
   assign w_shreg_shift = r_shreg >> DATA;

   // Moore-style strobes decoded from the state register. tx_start is also
   // gated by tx_busy so a start is never offered to a busy transmitter.
   assign pop      = (r_state == S_POP);
   assign tx_start = (r_state == S_START) && !tx_busy;
   assign busy     = (r_state != S_IDLE);

   // Sequencer: word fetch, per-byte handshake, ack timeout/retry, counters.
   always_ff @(posedge sys_clk or posedge sys_rst_l) begin
      if (sys_rst_l) begin
         r_state     <= S_IDLE;
         r_shreg     <= '0;
         r_byte_cnt  <= '0;
         r_to_cnt    <= '0;
         r_retry_cnt <= '0;
         tx_data     <= '0;
         err         <= 1'b0;
         words_sent  <= '0;
      end else begin
         // Clear first so that an abort in the same cycle overrides it.
         if (clr_err) begin
            err <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               // en and fifo_empty only matter here; a word in flight
               // always completes.
               if (en && !fifo_empty) begin
                  r_state <= S_POP;
               end
            end

            S_POP: begin
               r_state <= S_CAPT;
            end

            S_CAPT: begin
               // FIFO read data is valid the cycle after the pop strobe.
               // tx_data is loaded here as well so it is already correct
               // in the cycle tx_start is first offered.
               r_shreg     <= fifo_dout;
               tx_data     <= fifo_dout[DATA-1:0];
               r_byte_cnt  <= '0;
               r_retry_cnt <= '0;
               r_state     <= S_START;
            end

            S_START: begin
               tx_data <= r_shreg[DATA-1:0];
               if (!tx_busy) begin
                  r_to_cnt <= '0;
                  r_state  <= S_ACK;
               end
            end

            S_ACK: begin
               if (tx_busy) begin
                  r_state <= S_DONE;
               end else if (r_to_cnt == c_to_last) begin
                  if (r_retry_cnt < c_max_retry) begin
                     // Re-offer the same byte.
                     r_retry_cnt <= r_retry_cnt + c_rt_one;
                     r_state     <= S_START;
                  end else begin
                     // Retries exhausted: the rest of the word is dropped
                     // and not counted.
                     err     <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_to_cnt <= r_to_cnt + c_to_one;
               end
            end

            S_DONE: begin
               if (!tx_busy) begin
                  if (r_byte_cnt == c_last_byte) begin
                     words_sent <= words_sent + 16'd1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_shreg     <= w_shreg_shift;
                     tx_data     <= w_shreg_shift[DATA-1:0];
                     r_byte_cnt  <= r_byte_cnt + c_bc_one;
                     r_retry_cnt <= '0;
                     r_state     <= S_START;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_to_utx_ctrl.sv
// ============================================================================
// Module   : tb_fifo_to_utx_ctrl
// Brief    : Self-checking bench for fifo_to_utx_ctrl. A FIFO model and a
//            transmitter model drive the DUT; a monitor turns every popped
//            word into its expected byte sequence and checks each tx_start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_to_utx_ctrl;

   localparam int DATA_FIFO = 64;
   localparam int DATA      = 8;
   localparam int N_BYTES   = 8;
   localparam int ACK_TO    = 16;
   localparam int MAX_RETRY = 3;

   logic                 sys_clk;
   logic                 sys_rst_l;
   logic                 en;
   logic                 clr_err;
   logic                 fifo_empty;
   logic [DATA_FIFO-1:0] fifo_dout;
   logic                 pop;
   logic                 tx_busy;
   logic                 tx_start;
   logic [DATA-1:0]      tx_data;
   logic                 busy;
   logic                 err;
   logic [15:0]          words_sent;

   fifo_to_utx_ctrl #(
      .DATA_FIFO (DATA_FIFO),
      .DATA      (DATA),
      .N_BYTES   (N_BYTES),
      .ACK_TO    (ACK_TO),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_l  (sys_rst_l),
      .en         (en),
      .clr_err    (clr_err),
      .fifo_empty (fifo_empty),
      .fifo_dout  (fifo_dout),
      .pop        (pop),
      .tx_busy    (tx_busy),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .busy       (busy),
      .err        (err),
      .words_sent (words_sent)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Stimulus-owned models
   logic [DATA_FIFO-1:0] fifo_q[$];
   int  rise_cnt, hold_cnt, hold_len, exp_words;
   bit  tx_never;

   // Monitor-owned scoreboard
   logic [DATA-1:0] exp_q[$];
   int  start_cyc[$];
   int  pops_seen = 0, starts_seen = 0, acks_seen = 0, mon_cyc = 0;
   bit  m_prev_busy = 1'b0, m_prev_err = 1'b0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endfunction

   // One clock of the FIFO and transmitter models.
   task automatic tick();
      @(negedge sys_clk);
      if (rise_cnt > 0) begin
         rise_cnt--;
         if (rise_cnt == 0) begin
            tx_busy  = 1'b1;
            hold_cnt = hold_len;
         end
      end else if (tx_busy) begin
         hold_cnt--;
         if (hold_cnt <= 0) tx_busy = 1'b0;
      end
      #1;
      if (pop === 1'b1) begin
         chk("pop_while_empty", fifo_q.size() != 0, 1);
         if (fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
         fifo_empty = (fifo_q.size() == 0);
      end
      if (tx_start === 1'b1 && !tx_never) rise_cnt = 2;
   endtask

   task automatic push_word(input logic [DATA_FIFO-1:0] w);
      fifo_q.push_back(w);
      fifo_empty = 1'b0;
      exp_words++;
   endtask

   function automatic bit quiet();
      return (busy === 1'b0) && (fifo_q.size() == 0) && !tx_busy && (rise_cnt == 0);
   endfunction

   task automatic wait_quiet(input string name, input int max);
      int k;
      for (k = 0; k < max; k++) begin
         tick();
         if (quiet()) break;
      end
      chk(name, k < max, 1);
   endtask

   // Monitor: expected bytes come from each popped word; every tx_start is
   // compared with the head; a transmitter acknowledge retires the head.
   initial begin
      logic [DATA_FIFO-1:0] w;
      forever begin
         @(negedge sys_clk);
         #2;
         mon_cyc++;
         if (sys_rst_l) begin
            exp_q.delete();
            m_prev_busy = 1'b0;
            m_prev_err  = 1'b0;
         end else begin
            if (pop === 1'b1) begin
               pops_seen++;
               w = fifo_dout;
               for (int i = 0; i < N_BYTES; i++) exp_q.push_back(w[DATA*i +: DATA]);
            end
            if (tx_start === 1'b1) begin
               starts_seen++;
               start_cyc.push_back(mon_cyc);
               if (exp_q.size() == 0) chk("unexpected_tx_start", 1, 0);
               else                   chk("tx_data", tx_data, exp_q[0]);
            end
            if (tx_busy && !m_prev_busy) begin
               acks_seen++;
               if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (err === 1'b1 && !m_prev_err) exp_q.delete();
            m_prev_busy = tx_busy;
            m_prev_err  = (err === 1'b1);
         end
      end
   end

   initial begin
      int p0, s0, a0, k, cnt, n;
      sys_rst_l = 1'b1; en = 1'b0; clr_err = 1'b0; fifo_empty = 1'b1;
      tx_busy = 1'b0; fifo_dout = '0; hold_len = 10; tx_never = 1'b0;
      rise_cnt = 0; hold_cnt = 0; exp_words = 0;
      repeat (3) tick();
      chk("rst_pop", pop, 0);       chk("rst_tx_start", tx_start, 0);
      chk("rst_busy", busy, 0);     chk("rst_err", err, 0);
      chk("rst_tx_data", tx_data, 0); chk("rst_words", words_sent, 0);
      sys_rst_l = 1'b0;
      tick();

      // 1: single known word
      p0 = pops_seen; s0 = starts_seen; a0 = acks_seen;
      push_word(64'h8877665544332211);
      en = 1'b1;
      wait_quiet("t1_timeout", 1000);
      chk("t1_pops", pops_seen - p0, 1);
      chk("t1_starts", starts_seen - s0, 8);
      chk("t1_acks", acks_seen - a0, 8);
      chk("t1_words", words_sent, 1);
      chk("t1_busy", busy, 0);
      chk("t1_left", exp_q.size(), 0);

      // 2: empty FIFO, enabled -> nothing happens
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (pop !== 1'b0 || tx_start !== 1'b0 || busy !== 1'b0) cnt++;
      end
      chk("t2_activity", cnt, 0);

      // 3: two queued words
      p0 = pops_seen; s0 = starts_seen;
      push_word({$urandom, $urandom});
      push_word({$urandom, $urandom});
      wait_quiet("t3_timeout", 2000);
      chk("t3_pops", pops_seen - p0, 2);
      chk("t3_starts", starts_seen - s0, 16);
      chk("t3_words", words_sent, exp_words);
      chk("t3_left", exp_q.size(), 0);

      // 4: en drops after byte 3 of a word
      p0 = pops_seen; s0 = starts_seen; a0 = acks_seen;
      push_word({$urandom, $urandom});
      push_word({$urandom, $urandom});
      for (k = 0; k < 1000 && (acks_seen - a0) < 3; k++) tick();
      en = 1'b0;
      for (k = 0; k < 1000; k++) begin
         tick();
         if (busy === 1'b0 && !tx_busy && rise_cnt == 0) break;
      end
      chk("t4_timeout", k < 1000, 1);
      repeat (50) tick();
      chk("t4_pops", pops_seen - p0, 1);
      chk("t4_starts", starts_seen - s0, 8);
      chk("t4_fifo_kept", fifo_q.size(), 1);
      chk("t4_words", words_sent, exp_words - 1);
      en = 1'b1;
      wait_quiet("t4_drain_timeout", 1000);
      chk("t4_words_after", words_sent, exp_words);

      // 5: transmitter never acknowledges -> retries, abort, err
      tx_never = 1'b1;
      s0 = starts_seen;
      push_word({$urandom, $urandom});
      exp_words--;
      for (k = 0; k < 300 && err !== 1'b1; k++) tick();
      chk("t5_err_timeout", k < 300, 1);
      repeat (3) tick();
      chk("t5_err", err, 1);
      chk("t5_busy", busy, 0);
      chk("t5_starts", starts_seen - s0, MAX_RETRY + 1);
      if (starts_seen - s0 == MAX_RETRY + 1)
         for (int i = 1; i <= MAX_RETRY; i++)
            chk("t5_spacing", start_cyc[s0 + i] - start_cyc[s0 + i - 1], ACK_TO + 1);
      chk("t5_words", words_sent, exp_words);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      tick();
      chk("t5_clr_err", err, 0);
      tx_never = 1'b0;

      // 6: asynchronous reset while waiting for ack of byte 5
      a0 = acks_seen; s0 = starts_seen;
      push_word({$urandom, $urandom});
      for (k = 0; k < 1000 && (acks_seen - a0) < 4; k++) tick();
      tx_never = 1'b1;
      for (k = 0; k < 1000 && (starts_seen - s0) < 5; k++) tick();
      repeat (3) tick();
      chk("t6_in_flight", busy, 1);
      #2 sys_rst_l = 1'b1;
      #1;
      chk("t6_rst_pop", pop, 0);         chk("t6_rst_tx_start", tx_start, 0);
      chk("t6_rst_busy", busy, 0);       chk("t6_rst_err", err, 0);
      chk("t6_rst_tx_data", tx_data, 0); chk("t6_rst_words", words_sent, 0);
      tx_busy = 1'b0; rise_cnt = 0; hold_cnt = 0; tx_never = 1'b0;
      exp_words = 0;
      repeat (2) tick();
      sys_rst_l = 1'b0;
      s0 = starts_seen;
      push_word(64'h0F0E0D0C0B0A0908);
      wait_quiet("t6_timeout", 1000);
      chk("t6_starts", starts_seen - s0, 8);
      chk("t6_words", words_sent, 1);
      chk("t6_left", exp_q.size(), 0);

      // 7: random words, random transmitter hold time, random en
      for (int r = 0; r < 4; r++) begin
         hold_len = $urandom_range(1, 12);
         n = $urandom_range(1, 3);
         p0 = pops_seen;
         for (int j = 0; j < n; j++) push_word({$urandom, $urandom});
         for (k = 0; k < 1500; k++) begin
            en = ($urandom_range(0, 3) != 0);
            tick();
            if (quiet()) break;
         end
         en = 1'b1;
         wait_quiet("t7_timeout", 2000);
         chk("t7_pops", pops_seen - p0, n);
         chk("t7_words", words_sent, exp_words);
         chk("t7_left", exp_q.size(), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
